// File: rtl/alu_pkg.sv
// Shared opcode encoding and default width for the registered ALU.
// Consumers: alu_core, alu_top (optional input stage via ALU_INPUT_REG_EN).
package alu_pkg;

  localparam int ALU_DEFAULT_N = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational four-function ALU; bit N carries the add carry-out
// or the subtract borrow, and is always zero for the logical operations.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = ALU_DEFAULT_N
) (
  input  logic [N-1:0] operand1,
  input  logic [N-1:0] operand2,
  input  alu_op_t      operation,
  output logic [N:0]   value
);

  logic [N:0] ext1;
  logic [N:0] ext2;

  assign ext1 = {1'b0, operand1};
  assign ext2 = {1'b0, operand2};

  // Subtraction wraps mod 2^(N+1), so bit N doubles as "operand1 < operand2".
  always_comb begin
    value = '0;
    case (operation)
      ALU_ADD: value = ext1 + ext2;
      ALU_SUB: value = ext1 - ext2;
      ALU_AND: value = {1'b0, operand1 & operand2};
      ALU_OR:  value = {1'b0, operand1 | operand2};
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// Registered ALU wrapper: output register always, plus an input register
// stage when ALU_INPUT_REG_EN is defined (latency 2 instead of 1).
module alu_top
  import alu_pkg::*;
#(
  parameter int N = ALU_DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] operand1,
  input  logic [N-1:0] operand2,
  input  logic [1:0]   operation,
  output logic [N:0]   result
);

  logic [N-1:0] core_op1;
  logic [N-1:0] core_op2;
  alu_op_t      core_op;
  logic [N:0]   core_value;

`ifdef ALU_INPUT_REG_EN
  logic [N-1:0] op1_q;
  logic [N-1:0] op2_q;
  alu_op_t      op_q;

  // Clearing to ADD 0+0 keeps the first post-reset output at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op1_q <= '0;
      op2_q <= '0;
      op_q  <= ALU_ADD;
    end else begin
      op1_q <= operand1;
      op2_q <= operand2;
      op_q  <= alu_op_t'(operation);
    end
  end

  assign core_op1 = op1_q;
  assign core_op2 = op2_q;
  assign core_op  = op_q;
`else
  assign core_op1 = operand1;
  assign core_op2 = operand2;
  assign core_op  = alu_op_t'(operation);
`endif

  alu_core #(
    .N (N)
  ) u_core (
    .operand1  (core_op1),
    .operand2  (core_op2),
    .operation (core_op),
    .value     (core_value)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      result <= '0;
    end else begin
      result <= core_value;
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Directed bench for alu_top: table of single operations, a back-to-back
// stream with a mid-stream reset, and the latency check for ALU_INPUT_REG_EN.
module tb_alu_top;
  import alu_pkg::*;

  localparam int N = 4;
`ifdef ALU_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] operand1;
  logic [N-1:0] operand2;
  logic [1:0]   operation;
  logic [N:0]   result;

  int compared;
  int mismatched;

  typedef struct {
    logic         rst;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N:0]   exp;
    string        name;
  } vec_t;

  vec_t vecs[14];
  vec_t stream[12];

  alu_top #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic [1:0] op,
                               input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    reset     = rst;
    operation = op;
    operand1  = a;
    operand2  = b;
  endtask

  task automatic checkOutput(input string name, input logic [N:0] exp);
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: result=%0d (%b) expected=%0d (%b)", name, result, result, exp, exp);
    end
  endtask

  logic [N:0] model_stage;
  logic [N:0] model_res;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    operation  = ALU_ADD;
    operand1   = '0;
    operand2   = '0;

    vecs[0]  = '{1'b1, ALU_ADD, 4'd7,  4'd4,  5'd11, "add_7_4"};
    vecs[1]  = '{1'b1, ALU_ADD, 4'd7,  4'd10, 5'd17, "add_7_10_carry"};
    vecs[2]  = '{1'b1, ALU_ADD, 4'd15, 4'd15, 5'd30, "add_15_15"};
    vecs[3]  = '{1'b1, ALU_SUB, 4'd1,  4'd1,  5'd0,  "sub_1_1"};
    vecs[4]  = '{1'b1, ALU_SUB, 4'd0,  4'd2,  5'd30, "sub_0_2_borrow"};
    vecs[5]  = '{1'b1, ALU_SUB, 4'd9,  4'd3,  5'd6,  "sub_9_3"};
    vecs[6]  = '{1'b1, ALU_SUB, 4'd0,  4'd15, 5'd17, "sub_0_15"};
    vecs[7]  = '{1'b1, ALU_SUB, 4'd15, 4'd14, 5'd1,  "sub_15_14"};
    vecs[8]  = '{1'b1, ALU_AND, 4'd1,  4'd1,  5'd1,  "and_1_1"};
    vecs[9]  = '{1'b1, ALU_AND, 4'd6,  4'd3,  5'd2,  "and_6_3"};
    vecs[10] = '{1'b1, ALU_AND, 4'd15, 4'd15, 5'd15, "and_15_15"};
    vecs[11] = '{1'b1, ALU_OR,  4'd12, 4'd10, 5'd14, "or_12_10"};
    vecs[12] = '{1'b1, ALU_OR,  4'd11, 4'd2,  5'd11, "or_11_2"};
    vecs[13] = '{1'b1, ALU_OR,  4'd15, 4'd15, 5'd15, "or_15_15"};

    stream[0]  = '{1'b1, ALU_ADD, 4'd3,  4'd5,  5'd8,  "s0_add"};
    stream[1]  = '{1'b1, ALU_SUB, 4'd5,  4'd9,  5'd28, "s1_sub"};
    stream[2]  = '{1'b1, ALU_AND, 4'd12, 4'd5,  5'd4,  "s2_and"};
    stream[3]  = '{1'b1, ALU_OR,  4'd1,  4'd8,  5'd9,  "s3_or"};
    stream[4]  = '{1'b1, ALU_ADD, 4'd8,  4'd8,  5'd16, "s4_add"};
    stream[5]  = '{1'b0, ALU_SUB, 4'd2,  4'd1,  5'd1,  "s5_reset"};
    stream[6]  = '{1'b1, ALU_ADD, 4'd1,  4'd2,  5'd3,  "s6_add"};
    stream[7]  = '{1'b1, ALU_SUB, 4'd15, 4'd0,  5'd15, "s7_sub"};
    stream[8]  = '{1'b1, ALU_OR,  4'd5,  4'd10, 5'd15, "s8_or"};
    stream[9]  = '{1'b1, ALU_AND, 4'd15, 4'd9,  5'd9,  "s9_and"};
    stream[10] = '{1'b1, ALU_ADD, 4'd0,  4'd0,  5'd0,  "s10_drain"};
    stream[11] = '{1'b1, ALU_ADD, 4'd0,  4'd0,  5'd0,  "s11_drain"};

    // Reset held for two edges with zero ADD inputs.
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_zero", 5'd0);

    // Reset dominates a non-zero operation and clears every stage.
    applyStimulus(1'b0, ALU_ADD, 4'd15, 4'd15);
    repeat (LAT + 1) @(posedge clk);
    #1 checkOutput("reset_dominates", 5'd0);

    applyStimulus(1'b1, ALU_ADD, 4'd0, 4'd1);
`ifdef ALU_INPUT_REG_EN
    @(posedge clk);
    #1 checkOutput("post_reset_stage_cleared", 5'd0);
    @(posedge clk);
`else
    @(posedge clk);
`endif
    #1 checkOutput("post_reset_add_0_1", 5'd1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].a, vecs[i].b);
      repeat (LAT) @(posedge clk);
      #1 checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Back-to-back stream: expected result tracked through the pipeline depth.
    model_stage = result;
    model_res   = result;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(stream[i].rst, stream[i].op, stream[i].a, stream[i].b);
      @(posedge clk);
      if (!stream[i].rst) begin
        model_stage = '0;
        model_res   = '0;
      end else begin
`ifdef ALU_INPUT_REG_EN
        model_res   = model_stage;
        model_stage = stream[i].exp;
`else
        model_res   = stream[i].exp;
`endif
      end
      #1 checkOutput(stream[i].name, model_res);
    end

`ifdef ALU_INPUT_REG_EN
    // Two-cycle latency: old stage content first, then the new sum.
    applyStimulus(1'b1, ALU_ADD, 4'd7, 4'd10);
    @(posedge clk);
    #1 checkOutput("inreg_add_first_edge", 5'd0);
    @(posedge clk);
    #1 checkOutput("inreg_add_7_10", 5'd17);
    applyStimulus(1'b0, ALU_OR, 4'd15, 4'd15);
    @(posedge clk);
    #1 checkOutput("inreg_reset_result", 5'd0);
    applyStimulus(1'b1, ALU_OR, 4'd15, 4'd15);
    @(posedge clk);
    #1 checkOutput("inreg_reset_stage", 5'd0);
    @(posedge clk);
    #1 checkOutput("inreg_recover", 5'd15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- Registered N-bit, four-function ALU (add, subtract, AND, OR) with an (N+1)-bit result.
- Bit N of the result carries the add carry-out or the subtract borrow/sign.
- Leaf datapath block: operands and opcode in, one registered result out.
- No handshake; a new operation may be issued every cycle.

Parameters:
- N, 4, operand width in bits (N >= 1); result is N+1 bits.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- operand1  input  N  first operand, unsigned.
- operand2  input  N  second operand, unsigned.
- operation  input  2  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR.
- result  output  N+1  registered result.

Behaviour:
- Reset: when reset==0 at a rising clk edge, result <= 0 (all pipeline registers also cleared). Reset dominates any operation presented in that cycle.
- Reset mid-stream: any in-flight result is discarded; the first valid result appears at the normal latency after reset is released.
- Latency is 1 cycle (default build). Inputs sampled at edge k appear on result after edge k; result holds between edges.
- Throughput: one operation per cycle. Inputs may change every cycle; there is no stall.
- ADD: result = {1'b0,operand1} + {1'b0,operand2}. Full N+1-bit sum; bit N = carry-out; never overflows.
- SUB: result = ({1'b0,operand1} - {1'b0,operand2}) mod 2^(N+1).
  - Bit N = 1 exactly when operand1 < operand2 (borrow).
  - Equal operands give 0.
- AND: result = {1'b0, operand1 & operand2}.
- OR: result = {1'b0, operand1 | operand2}.
- Bit N is always 0 for AND and OR.
- Opcode space is fully decoded; no illegal codes.
- No X propagation on result after the first reset edge.

Optional Feature:
- Macro ALU_INPUT_REG_EN.
- When defined: operand1, operand2 and operation are first captured in an input register stage. Total latency becomes 2 cycles and throughput stays 1 per cycle. Reset clears the input stage (operation = ADD, operands = 0) as well as result.
- When undefined: no input stage; latency is 1 cycle as specified above.

Decomposition:
- Package alu_pkg:
  - enum alu_op_t (2-bit): ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3.
  - localparam default width ALU_DEFAULT_N=4.
- Sub-module alu_core: purely combinational, parameterised by N. Takes operands and alu_op_t; outputs the unregistered N+1-bit value.
- alu_top wraps alu_core with the optional input register stage and the output register.

Test Plan:
- Reset: hold reset=0 for 2 edges with operand1=0, operand2=0, op=ADD -> result=0. Release reset; ADD 0+1 -> result=1 one cycle later.
- ADD: 7+4 -> 11 (5'b01011); 7+10 -> 17 (5'b10001, carry bit set); 15+15 -> 30.
- SUB: 1-1 -> 0; 0-2 -> 30 (5'b11110, borrow set); 9-3 -> 6.
- AND/OR: AND 1&1 -> 1; AND 6&3 -> 2; OR 12|10 -> 14; OR 11|2 -> 11. Bit 4 is 0 in every case.
- Back-to-back plus mid-stream reset: change op every cycle -> each result appears exactly 1 cycle later. Assert reset=0 mid-stream -> result=0 on that edge, and the pipeline recovers afterwards.
- ALU_INPUT_REG_EN defined: repeat the ADD 7+10 case -> 17 appears 2 cycles after the inputs are applied; reset clears both stages.
